// File: rtl/image_row_writer.sv
// Packs 96 input words into one container row and writes a burst of
// consecutive rows of one bank through the container write port.
module image_row_writer #(
    parameter int WORD_W    = 32,
    parameter int ROW_W     = 3072,
    parameter int ROW_AW    = 7,
    parameter int NUM_BANKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        bank,
    input  logic [ROW_AW-1:0] start_row,
    input  logic [7:0]        num_rows,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic [ROW_AW+1:0] waddr,
    output logic              we,
    output logic [ROW_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WPR  = ROW_W / WORD_W;
    localparam int CW   = $clog2(WPR);
    localparam int MAXR = 1 << ROW_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [1:0]          bank_q;
    logic [ROW_AW-1:0]   row_q;
    logic [7:0]          rows_left_q;
    logic [CW-1:0]       cnt_q;
    logic [ROW_W-1:0]    data_q;
    logic [ROW_AW+1:0]   waddr_q;
    logic                rdy_q;
    logic                we_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic                start_ok;
    logic                xfer;

    assign start_ok = (int'(bank) < NUM_BANKS) && (num_rows != 8'd0)
                    && (int'(num_rows) <= MAXR);
    assign xfer     = in_valid && rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bank_q      <= '0;
            row_q       <= '0;
            rows_left_q <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            waddr_q     <= '0;
            rdy_q       <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start && start_ok) begin
                        state_q     <= S_FILL;
                        bank_q      <= bank;
                        row_q       <= start_row;
                        rows_left_q <= num_rows;
                        cnt_q       <= '0;
                        rdy_q       <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (start) begin
                        err_q <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (xfer) begin
                        data_q[int'(cnt_q)*WORD_W +: WORD_W] <= in_data;
                        if (cnt_q == CW'(WPR-1)) begin
                            state_q <= S_WRITE;
                            cnt_q   <= '0;
                            rdy_q   <= 1'b0;
                            we_q    <= 1'b1;
                            waddr_q <= {bank_q, row_q};
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (rows_left_q == 8'd1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_FILL;
                        row_q       <= row_q + 1'b1;
                        rows_left_q <= rows_left_q - 8'd1;
                        rdy_q       <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // abort cancels the write pulse in the very cycle it is raised
    assign we       = we_q && !abort;
    assign in_ready = rdy_q;
    assign waddr    = waddr_q;
    assign wdata    = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_image_row_writer.sv
// Scoreboard bench for image_row_writer: driver pushes expected row writes,
// a monitor pops and compares them whenever we is high.
module tb_image_row_writer;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    bank = '0;
    logic [6:0]    start_row = '0;
    logic [7:0]    num_rows = '0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          in_ready;
    logic [8:0]    waddr;
    logic          we;
    logic [3071:0] wdata;
    logic          busy;
    logic          done;
    logic          err;

    image_row_writer dut (
        .clk(clk), .rst(rst), .start(start), .bank(bank),
        .start_row(start_row), .num_rows(num_rows), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .waddr(waddr), .we(we), .wdata(wdata), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]    addr;
        logic [3071:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          exp_done = 0;
    int          got_done = 0;
    int          got_err = 0;
    logic        prev_we = 1'b0;
    logic [31:0] wbuf[96];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // monitor: compares every write against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            prev_we <= 1'b0;
        end else begin
            if (we) begin
                chk("we_single_cycle", {63'd0, prev_we}, 64'd0);
                chk("in_ready_in_write", {63'd0, in_ready}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("waddr", {55'd0, waddr}, {55'd0, e.addr});
                    n_chk++;
                    if (wdata === e.data) begin
                        n_pass++;
                    end else begin
                        for (int k = 0; k < 96; k++)
                            if (wdata[32*k +: 32] !== e.data[32*k +: 32]) begin
                                $display("FAIL wdata word %0d: got %0h expected %0h",
                                         k, wdata[32*k +: 32], e.data[32*k +: 32]);
                                break;
                            end
                    end
                end
            end
            if (done) begin
                got_done++;
                chk("done_after_write", {63'd0, prev_we}, 64'd1);
            end
            if (err) got_err++;
            prev_we <= we;
        end
    end

    task automatic issue_start(input logic [1:0] b, input logic [6:0] r,
                               input logic [7:0] n);
        start = 1'b1; bank = b; start_row = r; num_rows = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: word k = k, 1: all ones, 2: random data with valid gaps
    task automatic run_burst(input logic [1:0] b, input logic [6:0] r,
                             input int n, input int mode, input int abort_at,
                             input int rst_at);
        int  idx;
        int  cyc;
        bit  v;
        logic rdy;
        wr_t e;
        issue_start(b, r, n[7:0]);
        for (int row = 0; row < n; row++) begin
            for (int k = 0; k < 96; k++)
                wbuf[k] = (mode == 0) ? 32'(k) :
                          (mode == 1) ? 32'hFFFF_FFFF : $urandom;
            if (abort_at < 0 && rst_at < 0) begin
                e.addr = {b, 7'((int'(r) + row) % 128)};
                e.data = '0;
                for (int k = 0; k < 96; k++) e.data[32*k +: 32] = wbuf[k];
                exp_q.push_back(e);
            end
            idx = 0;
            cyc = 0;
            while (idx < 96 && cyc < 3000) begin
                if (idx == abort_at) begin
                    in_valid = 1'b0;
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_busy", {63'd0, busy}, 64'd0);
                    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
                    return;
                end
                if (idx == rst_at) begin
                    in_valid = 1'b0;
                    rst = 1'b1;
                    #1;
                    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
                    chk("rst_busy", {63'd0, busy}, 64'd0);
                    chk("rst_we", {63'd0, we}, 64'd0);
                    chk("rst_waddr", {55'd0, waddr}, 64'd0);
                    chk("rst_wdata_zero", {63'd0, wdata == '0}, 64'd1);
                    @(negedge clk);
                    rst = 1'b0;
                    @(negedge clk);
                    return;
                end
                v = (mode == 2) ? ($urandom_range(0, 99) >= 30) : 1'b1;
                // occasional start while busy must be ignored
                start = (mode == 2) && ($urandom_range(0, 49) == 0);
                bank = 2'd3;
                in_valid = v;
                in_data = wbuf[idx];
                rdy = in_ready;
                @(negedge clk);
                start = 1'b0;
                if (v && rdy) idx++;
                cyc++;
            end
            in_valid = 1'b0;
            if (idx < 96) chk("fill_timeout", 64'd1, 64'd0);
        end
        exp_done++;
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        chk("idle_after_burst", {63'd0, busy}, 64'd0);
    endtask

    task automatic bad_start(input logic [1:0] b, input logic [7:0] n);
        issue_start(b, 7'd0, n);
        chk("err_pulse", {63'd0, err}, 64'd1);
        chk("err_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        chk("err_one_cycle", {63'd0, err}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        #1;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done_err", {62'd0, done, err}, 64'd0);
        chk("reset_waddr", {55'd0, waddr}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_burst(2'd0, 7'd1, 1, 0, -1, -1);
        run_burst(2'd2, 7'd127, 2, 1, -1, -1);
        bad_start(2'd3, 8'd1);
        bad_start(2'd0, 8'd0);
        bad_start(2'd1, 8'd129);
        for (int t = 0; t < 4; t++)
            run_burst(2'($urandom_range(0, 2)), 7'($urandom),
                      $urandom_range(1, 3), 2, -1, -1);
        run_burst(2'd1, 7'd120, 16, 2, -1, -1);
        run_burst(2'd0, 7'd5, 1, 2, 51, -1);
        run_burst(2'd1, 7'd9, 1, 2, -1, -1);
        run_burst(2'd2, 7'd33, 2, 2, -1, 20);
        run_burst(2'd0, 7'd1, 1, 0, -1, -1);

        repeat (3) @(negedge clk);
        chk("done_count", 64'(got_done), 64'(exp_done));
        chk("err_count", 64'(got_err), 64'd3);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
